gray_reader: RTL
================

# gray_reader

Receiving end of the Gray-code count bus driven by the team's Gray counter. Registers the Gray bus every cycle, decodes it to binary, and checks that the sequence only holds or steps +1 modulo 2^WIDTH. On a capture strobe, it snapshots the decoded count into a 2-entry buffer, which is drained through a valid/ready handshake. It sits between the counter and the readout logic, replacing ad-hoc combinational decoding at the consumer.

## Interface
- WIDTH, 8, width of the Gray bus and of the binary outputs (≥2)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge; 0 = reset
- gray_in  in  WIDTH  Gray-coded count from the counter, same clock domain
- capture  in  1  snapshot request, aligned with the gray_in value to be captured
- out_ready  in  1  consumer accepts out_data this edge
- out_valid  out  1  buffer head valid
- out_data  out  WIDTH  binary value at buffer head
- count_out  out  WIDTH  binary decode of the registered Gray value (running monitor)
- step_error  out  1  sticky: illegal Gray sequence seen
- overrun  out  1  sticky: a capture was dropped because the buffer was full

## Operation
- Decode rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is the inverse of the counter's encoding.
- Input stage: gray_q <= gray_in every edge. cap_q <= capture every edge. count_out = decode(gray_q).
- Prime flag: cleared by reset, set on the first non-reset edge.
- Step check, on each edge with primed=1:
  - Let n = decode(gray_in) and p = decode(gray_q).
  - Legal iff n == p or n == (p+1) mod 2^WIDTH.
  - Otherwise step_error <= 1. It stays set until reset.
- Wrap: p = 2^WIDTH-1 followed by n = 0 is legal.
- Buffer: 2-entry FIFO of WIDTH-bit binary values.
  - Push on an edge with cap_q=1; the pushed value is decode(gray_q).
  - Pop on an edge with out_valid && out_ready.
  - Push and pop on the same edge: both occur. This holds even when full; the pushed value enters behind the remaining entry, and no overrun is flagged.
  - Push when full without pop: the new value is discarded and overrun <= 1 (sticky).
  - Pop when empty: no effect.
- out_data is the FIFO head. It is held stable while out_valid && !out_ready.
- States of the buffer: EMPTY, ONE, FULL. Transitions follow push/pop as above.

## Timing
- All outputs are 0 during reset and on the first edge after reset deasserts: out_valid, out_data, count_out, step_error, overrun.
- Reset mid-operation:
  - FIFO contents are discarded.
  - Both sticky flags clear.
  - capture and gray_in sampled while reset=0 are ignored; no push occurs from them.
- count_out latency: 1 edge after gray_in.
- step_error: set immediately after the edge that samples the illegal gray_in.
- Capture latency: gray_in/capture sampled at edge E0; the entry is written at E1; out_valid = 1 after E1 (2 edges total) if the FIFO was empty.
- Throughput: one capture per cycle is sustained when out_ready is held high.
- The first code after reset is never checked against a prior value.

## Test plan
1. Reset: reset=0 for 3 cycles with gray_in=0x55 and capture=1 -> all outputs 0 throughout and the cycle after release; no entry appears.
2. Single capture: gray_in counts 0x00,0x01,0x03,0x02,0x06,0x07; capture=1 with 0x07; out_ready=1 -> out_valid rises 2 edges later with out_data=0x05, then falls on the next edge; step_error=0.
3. Backpressure/overrun: out_ready=0; captures at gray 0x02, 0x06, 0x07 (bin 3, 4, 5) -> out_data=3 held, 4 queued, 5 dropped, overrun=1; then out_ready=1 -> reads 3, 4, then out_valid=0; overrun stays 1.
4. Full with simultaneous pop/push: FIFO holds 3 and 4; out_ready=1 on the edge where cap_q pushes bin 6 (gray 0x05) -> no overrun; read sequence 3, 4, 6.
5. Wrap: gray_in 0x81 (bin 254), 0x80 (255), 0x00 (0), 0x01 (1) -> count_out 254, 255, 0, 1; step_error stays 0.
6. Step error: gray 0x07 (bin 5) then 0x02 (bin 3) -> step_error=1 after that edge; it remains 1 through later legal steps and holds; a reset pulse clears it to 0.

Source files
------------

// File: rtl/gray_reader_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | gray_reader_if : Gray count bus in, capture/readout handshake out |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface gray_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             capture;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] count_out;
  logic             step_error;
  logic             overrun;

  modport master (
    output gray_in, capture, out_ready,
    input  out_valid, out_data, count_out, step_error, overrun
  );

  modport slave (
    input  gray_in, capture, out_ready,
    output out_valid, out_data, count_out, step_error, overrun
  );
endinterface
`default_nettype wire

// File: rtl/gray_reader.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | gray_reader : registers/decodes a Gray count, checks its steps,   |
// | and snapshots captured values into a 2-entry readout buffer.      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module gray_reader #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  gray_reader_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  buf_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_cap_q;
  logic             r_primed;
  logic             r_step_err;
  logic             r_overrun;
  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_inc;
  logic             w_push;
  logic             w_pop;

  // r_count holds decode(gray_q), so it is both the step reference and the push value
  assign w_next = gray2bin(bus.gray_in);
  assign w_inc  = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_push = r_cap_q;
  assign w_pop  = (r_state != EMPTY) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_count    <= '0;
      r_cap_q    <= 1'b0;
      r_primed   <= 1'b0;
      r_step_err <= 1'b0;
      r_overrun  <= 1'b0;
      r_mem0     <= '0;
      r_mem1     <= '0;
    end else begin
      r_primed <= 1'b1;
      r_count  <= w_next;
      r_cap_q  <= bus.capture;
      if (r_primed && (w_next != r_count) && (w_next != w_inc)) begin
        r_step_err <= 1'b1;
      end
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_mem0  <= r_count;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({w_push, w_pop})
            2'b11: r_mem0 <= r_count;
            2'b10: begin
              r_mem1  <= r_count;
              r_state <= FULL;
            end
            2'b01: r_state <= EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          // simultaneous pop makes room, so a push while full is not an overrun
          case ({w_push, w_pop})
            2'b11: begin
              r_mem0 <= r_mem1;
              r_mem1 <= r_count;
            end
            2'b10: r_overrun <= 1'b1;
            2'b01: begin
              r_mem0  <= r_mem1;
              r_state <= ONE;
            end
            default: ;
          endcase
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.out_valid  = (r_state != EMPTY);
  assign bus.out_data   = r_mem0;
  assign bus.count_out  = r_count;
  assign bus.step_error = r_step_err;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire
